// File: rtl/axi4sram_slvif_buf.sv
// AXI4 SRAM slave-interface buffer stage.
// AW/AR channels pass through 2-entry skid buffers, W through a small FIFO,
// B through a 1-entry register. The R path is a pass-through unless
// AXI4SRAM_SLVIF_RSLICE_EN is defined, which inserts a 2-entry skid buffer.

module axi4sram_slvif_skid2 #(
  parameter int W = 8
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic         in_en,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  // Ready comes straight from the held-entry count, so it never depends on out_ready.
  assign in_ready  = in_en && (cnt != 2'd2);
  assign push      = in_valid && in_ready;
  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  // Two-slot ring with occupancy count.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end
endmodule

module axi4sram_slvif_buf #(
  parameter int AXI4_DWIDTH  = 64,
  parameter int AXI4_AWIDTH  = 32,
  parameter int AXI4_IDWIDTH = 4,
  parameter int WFIFO_DEPTH  = 4
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [AXI4_IDWIDTH-1:0]      AWID_S,
  input  logic [AXI4_AWIDTH-1:0]       AWADDR_S,
  input  logic [7:0]                   AWLEN_S,
  input  logic [2:0]                   AWSIZE_S,
  input  logic [1:0]                   AWBURST_S,
  input  logic                         AWVALID_S,
  output logic                         AWREADY_S,
  input  logic [AXI4_DWIDTH-1:0]       WDATA_S,
  input  logic [AXI4_DWIDTH/8-1:0]     WSTRB_S,
  input  logic                         WLAST_S,
  input  logic                         WVALID_S,
  output logic                         WREADY_S,
  output logic [AXI4_IDWIDTH-1:0]      BID_S,
  output logic [1:0]                   BRESP_S,
  output logic                         BVALID_S,
  input  logic                         BREADY_S,
  input  logic [AXI4_IDWIDTH-1:0]      ARID_S,
  input  logic [AXI4_AWIDTH-1:0]       ARADDR_S,
  input  logic [7:0]                   ARLEN_S,
  input  logic [2:0]                   ARSIZE_S,
  input  logic [1:0]                   ARBURST_S,
  input  logic                         ARVALID_S,
  output logic                         ARREADY_S,
  output logic [AXI4_IDWIDTH-1:0]      RID_S,
  output logic [AXI4_DWIDTH-1:0]       RDATA_S,
  output logic [1:0]                   RRESP_S,
  output logic                         RLAST_S,
  output logic                         RVALID_S,
  input  logic                         RREADY_S,
  output logic [AXI4_IDWIDTH-1:0]      awid_mc,
  output logic [AXI4_AWIDTH-1:0]       awaddr_mc,
  output logic [7:0]                   awlen_mc,
  output logic [2:0]                   awsize_mc,
  output logic [1:0]                   awburst_mc,
  output logic                         awvalid_mc,
  input  logic                         awready_mc,
  output logic [AXI4_IDWIDTH-1:0]      arid_mc,
  output logic [AXI4_AWIDTH-1:0]       araddr_mc,
  output logic [7:0]                   arlen_mc,
  output logic [2:0]                   arsize_mc,
  output logic [1:0]                   arburst_mc,
  output logic                         arvalid_mc,
  input  logic                         arready_mc,
  output logic [AXI4_DWIDTH-1:0]       wdata_mc,
  output logic [AXI4_DWIDTH/8-1:0]     wstrb_mc,
  output logic                         wlast_mc,
  output logic                         wvalid_mc,
  input  logic                         wready_mc,
  input  logic [AXI4_IDWIDTH-1:0]      bid_mc,
  input  logic [1:0]                   bresp_mc,
  input  logic                         bvalid_mc,
  output logic                         bready_mc,
  input  logic [AXI4_IDWIDTH-1:0]      rid_mc,
  input  logic [AXI4_DWIDTH-1:0]       rdata_mc,
  input  logic [1:0]                   rresp_mc,
  input  logic                         rlast_mc,
  input  logic                         rvalid_mc,
  output logic                         rready_mc,
  output logic [$clog2(WFIFO_DEPTH):0] wfifo_level
);
  localparam int SW  = AXI4_DWIDTH / 8;
  localparam int PW  = $clog2(WFIFO_DEPTH);
  localparam int LW  = PW + 1;
  localparam int AXW = AXI4_IDWIDTH + AXI4_AWIDTH + 8 + 3 + 2;
  localparam int WW  = AXI4_DWIDTH + SW + 1;

  logic ready_en;

  // Hold all slave-side readies low until the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  axi4sram_slvif_skid2 #(.W(AXW)) u_aw_skid (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .in_en     (ready_en),
    .in_data   ({AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S}),
    .in_valid  (AWVALID_S),
    .in_ready  (AWREADY_S),
    .out_data  ({awid_mc, awaddr_mc, awlen_mc, awsize_mc, awburst_mc}),
    .out_valid (awvalid_mc),
    .out_ready (awready_mc)
  );

  axi4sram_slvif_skid2 #(.W(AXW)) u_ar_skid (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .in_en     (ready_en),
    .in_data   ({ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S}),
    .in_valid  (ARVALID_S),
    .in_ready  (ARREADY_S),
    .out_data  ({arid_mc, araddr_mc, arlen_mc, arsize_mc, arburst_mc}),
    .out_valid (arvalid_mc),
    .out_ready (arready_mc)
  );

  logic [WW-1:0] wmem [WFIFO_DEPTH];
  logic [PW-1:0] w_wr_ptr;
  logic [PW-1:0] w_rd_ptr;
  logic          w_push;
  logic          w_pop;

  // Full blocks the push even when a pop happens in the same cycle.
  assign WREADY_S  = ready_en && (wfifo_level < LW'(WFIFO_DEPTH));
  assign wvalid_mc = (wfifo_level != '0);
  assign w_push    = WVALID_S && WREADY_S;
  assign w_pop     = wvalid_mc && wready_mc;
  assign {wdata_mc, wstrb_mc, wlast_mc} = wmem[w_rd_ptr];

  // W FIFO storage, pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < WFIFO_DEPTH; i++) wmem[i] <= '0;
      w_wr_ptr    <= '0;
      w_rd_ptr    <= '0;
      wfifo_level <= '0;
    end else begin
      if (w_push) begin
        wmem[w_wr_ptr] <= {WDATA_S, WSTRB_S, WLAST_S};
        w_wr_ptr       <= w_wr_ptr + PW'(1);
      end
      if (w_pop) w_rd_ptr <= w_rd_ptr + PW'(1);
      wfifo_level <= wfifo_level + LW'(w_push) - LW'(w_pop);
    end
  end

  assign bready_mc = !BVALID_S || BREADY_S;

  // Single-entry B response holding register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      BVALID_S <= 1'b0;
      BID_S    <= '0;
      BRESP_S  <= 2'b00;
    end else if (bvalid_mc && bready_mc) begin
      BVALID_S <= 1'b1;
      BID_S    <= bid_mc;
      BRESP_S  <= bresp_mc;
    end else if (BREADY_S) begin
      BVALID_S <= 1'b0;
    end
  end

`ifdef AXI4SRAM_SLVIF_RSLICE_EN
  axi4sram_slvif_skid2 #(.W(AXI4_IDWIDTH + AXI4_DWIDTH + 3)) u_r_skid (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .in_en     (1'b1),
    .in_data   ({rid_mc, rdata_mc, rresp_mc, rlast_mc}),
    .in_valid  (rvalid_mc),
    .in_ready  (rready_mc),
    .out_data  ({RID_S, RDATA_S, RRESP_S, RLAST_S}),
    .out_valid (RVALID_S),
    .out_ready (RREADY_S)
  );
`else
  assign RID_S     = rid_mc;
  assign RDATA_S   = rdata_mc;
  assign RRESP_S   = rresp_mc;
  assign RLAST_S   = rlast_mc;
  assign RVALID_S  = rvalid_mc;
  assign rready_mc = RREADY_S;
`endif
endmodule

// File: tb/tb_axi4sram_slvif_buf.sv
// Directed self-checking bench for axi4sram_slvif_buf (default parameters).

module tb_axi4sram_slvif_buf;
  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [3:0]  AWID_S, ARID_S, BID_S, RID_S;
  logic [31:0] AWADDR_S, ARADDR_S;
  logic [7:0]  AWLEN_S, ARLEN_S;
  logic [2:0]  AWSIZE_S, ARSIZE_S;
  logic [1:0]  AWBURST_S, ARBURST_S, BRESP_S, RRESP_S;
  logic        AWVALID_S, AWREADY_S, WLAST_S, WVALID_S, WREADY_S;
  logic        BVALID_S, BREADY_S, ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S;
  logic [63:0] WDATA_S, RDATA_S;
  logic [7:0]  WSTRB_S;
  logic [3:0]  awid_mc, arid_mc, bid_mc, rid_mc;
  logic [31:0] awaddr_mc, araddr_mc;
  logic [7:0]  awlen_mc, arlen_mc;
  logic [2:0]  awsize_mc, arsize_mc;
  logic [1:0]  awburst_mc, arburst_mc, bresp_mc, rresp_mc;
  logic        awvalid_mc, awready_mc, arvalid_mc, arready_mc;
  logic [63:0] wdata_mc, rdata_mc;
  logic [7:0]  wstrb_mc;
  logic        wlast_mc, wvalid_mc, wready_mc, bvalid_mc, bready_mc;
  logic        rlast_mc, rvalid_mc, rready_mc;
  logic [2:0]  wfifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ACLK = ~ACLK;

  axi4sram_slvif_buf dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S),
    .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .awid_mc(awid_mc), .awaddr_mc(awaddr_mc), .awlen_mc(awlen_mc), .awsize_mc(awsize_mc),
    .awburst_mc(awburst_mc), .awvalid_mc(awvalid_mc), .awready_mc(awready_mc),
    .arid_mc(arid_mc), .araddr_mc(araddr_mc), .arlen_mc(arlen_mc), .arsize_mc(arsize_mc),
    .arburst_mc(arburst_mc), .arvalid_mc(arvalid_mc), .arready_mc(arready_mc),
    .wdata_mc(wdata_mc), .wstrb_mc(wstrb_mc), .wlast_mc(wlast_mc), .wvalid_mc(wvalid_mc),
    .wready_mc(wready_mc),
    .bid_mc(bid_mc), .bresp_mc(bresp_mc), .bvalid_mc(bvalid_mc), .bready_mc(bready_mc),
    .rid_mc(rid_mc), .rdata_mc(rdata_mc), .rresp_mc(rresp_mc), .rlast_mc(rlast_mc),
    .rvalid_mc(rvalid_mc), .rready_mc(rready_mc),
    .wfifo_level(wfifo_level)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] wbeat(input int b);
    return 64'hA5A5_0000_0000_0000 + 64'(b);
  endfunction

  function automatic logic [63:0] rbeat(input int b);
    return 64'h5A5A_0000_0000_1000 + 64'(b);
  endfunction

  // Directed stimulus sequence; inputs change on the falling edge only.
  initial begin
    int tx, rx;
    ARESETN = 1'b0;
    AWID_S = 4'h5; AWADDR_S = 32'h1000_0040; AWLEN_S = 8'd3; AWSIZE_S = 3'd3; AWBURST_S = 2'b01;
    AWVALID_S = 1'b1;
    WDATA_S = '0; WSTRB_S = '0; WLAST_S = 1'b0; WVALID_S = 1'b0;
    BREADY_S = 1'b0;
    ARID_S = '0; ARADDR_S = '0; ARLEN_S = '0; ARSIZE_S = '0; ARBURST_S = '0; ARVALID_S = 1'b0;
    RREADY_S = 1'b0;
    awready_mc = 1'b0; arready_mc = 1'b0; wready_mc = 1'b0;
    bid_mc = '0; bresp_mc = '0; bvalid_mc = 1'b0;
    rid_mc = '0; rdata_mc = '0; rresp_mc = '0; rlast_mc = 1'b0; rvalid_mc = 1'b0;

    @(negedge ACLK); @(negedge ACLK);
    check_val("rst_awready", AWREADY_S, 1'b0);
    check_val("rst_wready", WREADY_S, 1'b0);
    check_val("rst_arready", ARREADY_S, 1'b0);
    check_val("rst_awvalid_mc", awvalid_mc, 1'b0);
    check_val("rst_wvalid_mc", wvalid_mc, 1'b0);
    check_val("rst_bvalid", BVALID_S, 1'b0);
    check_val("rst_level", wfifo_level, 3'd0);

    // Reset release with AWVALID_S already high.
    ARESETN = 1'b1;
    #1 check_val("rel_awready_c0", AWREADY_S, 1'b0);
    @(negedge ACLK);
    check_val("rel_awready_c1", AWREADY_S, 1'b1);
    check_val("rel_awvalid_mc_c1", awvalid_mc, 1'b0);
    @(negedge ACLK);
    check_val("rel_awvalid_mc", awvalid_mc, 1'b1);
    check_val("rel_awaddr_mc", awaddr_mc, 32'h1000_0040);
    check_val("rel_awid_mc", awid_mc, 4'h5);
    check_val("rel_awlen_mc", awlen_mc, 8'd3);
    AWVALID_S = 1'b0; awready_mc = 1'b1;
    @(negedge ACLK);
    check_val("rel_aw_popped", awvalid_mc, 1'b0);
    awready_mc = 1'b0;

    // Two back-to-back AW requests with awready_mc held low.
    AWVALID_S = 1'b1; AWID_S = 4'h1; AWADDR_S = 32'h100;
    @(negedge ACLK);
    AWID_S = 4'h2; AWADDR_S = 32'h200;
    @(negedge ACLK);
    check_val("aw_full_rdy", AWREADY_S, 1'b0);
    AWID_S = 4'h3; AWADDR_S = 32'h300;
    @(negedge ACLK);
    check_val("aw_hold_rdy", AWREADY_S, 1'b0);
    check_val("aw_head_id1", awid_mc, 4'h1);
    check_val("aw_head_addr1", awaddr_mc, 32'h100);
    awready_mc = 1'b1;
    @(negedge ACLK);
    check_val("aw_head_id2", awid_mc, 4'h2);
    check_val("aw_rdy_back", AWREADY_S, 1'b1);
    @(negedge ACLK);
    check_val("aw_head_id3", awid_mc, 4'h3);
    check_val("aw_head_addr3", awaddr_mc, 32'h300);
    AWVALID_S = 1'b0;
    @(negedge ACLK);
    check_val("aw_drained", awvalid_mc, 1'b0);
    awready_mc = 1'b0;

    // AR single transfer.
    ARVALID_S = 1'b1; ARID_S = 4'h7; ARADDR_S = 32'h2000_0080; ARLEN_S = 8'd3;
    @(negedge ACLK);
    ARVALID_S = 1'b0;
    check_val("ar_valid_mc", arvalid_mc, 1'b1);
    check_val("ar_id_mc", arid_mc, 4'h7);
    check_val("ar_addr_mc", araddr_mc, 32'h2000_0080);
    arready_mc = 1'b1;
    @(negedge ACLK);
    check_val("ar_drained", arvalid_mc, 1'b0);
    arready_mc = 1'b0;

    // W FIFO fill past full, then drain.
    WVALID_S = 1'b1; WSTRB_S = 8'hFF;
    for (int b = 1; b <= 4; b++) begin
      WDATA_S = wbeat(b); WLAST_S = 1'b0;
      @(negedge ACLK);
    end
    WDATA_S = wbeat(5); WLAST_S = 1'b1; WSTRB_S = 8'h0F;
    check_val("w_full_level", wfifo_level, 3'd4);
    check_val("w_full_rdy", WREADY_S, 1'b0);
    @(negedge ACLK);
    check_val("w_full_hold", wfifo_level, 3'd4);
    check_val("w_beat1", wdata_mc, wbeat(1));
    wready_mc = 1'b1;
    @(negedge ACLK);
    check_val("w_popfull_level", wfifo_level, 3'd3);
    check_val("w_popfull_rdy", WREADY_S, 1'b1);
    check_val("w_beat2", wdata_mc, wbeat(2));
    @(negedge ACLK);
    WVALID_S = 1'b0;
    check_val("w_pushpop_level", wfifo_level, 3'd3);
    check_val("w_beat3", wdata_mc, wbeat(3));
    check_val("w_last3", wlast_mc, 1'b0);
    @(negedge ACLK);
    check_val("w_beat4", wdata_mc, wbeat(4));
    check_val("w_level2", wfifo_level, 3'd2);
    @(negedge ACLK);
    check_val("w_beat5", wdata_mc, wbeat(5));
    check_val("w_last5", wlast_mc, 1'b1);
    check_val("w_strb5", wstrb_mc, 8'h0F);
    @(negedge ACLK);
    check_val("w_empty_valid", wvalid_mc, 1'b0);
    check_val("w_empty_level", wfifo_level, 3'd0);
    wready_mc = 1'b0;

    // B response held while BREADY_S is low.
    bvalid_mc = 1'b1; bid_mc = 4'h3; bresp_mc = 2'b00;
    #1 check_val("b_bready_mc_idle", bready_mc, 1'b1);
    @(negedge ACLK);
    bvalid_mc = 1'b0; bid_mc = 4'h0;
    check_val("b_valid", BVALID_S, 1'b1);
    check_val("b_id", BID_S, 4'h3);
    check_val("b_resp", BRESP_S, 2'b00);
    check_val("b_bready_mc_busy", bready_mc, 1'b0);
    @(negedge ACLK);
    check_val("b_valid_hold", BVALID_S, 1'b1);
    BREADY_S = 1'b1;
    #1 check_val("b_bready_mc_drain", bready_mc, 1'b1);
    @(negedge ACLK);
    check_val("b_cleared", BVALID_S, 1'b0);
    BREADY_S = 1'b0;

`ifdef AXI4SRAM_SLVIF_RSLICE_EN
    // Four-beat read through the slice with a toggling RREADY_S.
    tx = 0; rx = 0;
    for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
      @(negedge ACLK);
      rvalid_mc = (tx < 4); rdata_mc = rbeat(tx); rlast_mc = (tx == 3); rid_mc = 4'h9;
      RREADY_S = cyc[0];
      #1;
      if (RVALID_S && RREADY_S) begin
        check_val("r_data", RDATA_S, rbeat(rx));
        check_val("r_last", RLAST_S, rx == 3);
        check_val("r_id", RID_S, 4'h9);
        rx++;
      end
      if (rvalid_mc && rready_mc) tx++;
    end
    check_val("r_beats_delivered", rx, 4);
    @(negedge ACLK);
    rvalid_mc = 1'b0; RREADY_S = 1'b0;
    check_val("r_no_dup", RVALID_S, 1'b0);
    rvalid_mc = 1'b1; rdata_mc = rbeat(0); rlast_mc = 1'b0;
    @(negedge ACLK);
    check_val("r_mid_valid", RVALID_S, 1'b1);
    #2 ARESETN = 1'b0;
    #1 check_val("r_rst_clear", RVALID_S, 1'b0);
    rvalid_mc = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
`else
    // Combinational R pass-through.
    tx = 0; rx = 0;
    rvalid_mc = 1'b1; rdata_mc = rbeat(7); rlast_mc = 1'b1; rid_mc = 4'h9; RREADY_S = 1'b0;
    #1;
    check_val("r_pt_valid", RVALID_S, 1'b1);
    check_val("r_pt_data", RDATA_S, rbeat(7));
    check_val("r_pt_last", RLAST_S, 1'b1);
    check_val("r_pt_ready_lo", rready_mc, 1'b0);
    RREADY_S = 1'b1;
    #1 check_val("r_pt_ready_hi", rready_mc, 1'b1);
    @(negedge ACLK);
    rvalid_mc = 1'b0; RREADY_S = 1'b0;
`endif

    // Reset in the middle of a W burst discards buffered beats.
    WVALID_S = 1'b1; WDATA_S = wbeat(9); WLAST_S = 1'b0; WSTRB_S = 8'hFF;
    @(negedge ACLK);
    @(negedge ACLK);
    check_val("wrst_level_pre", wfifo_level, 3'd2);
    #2 ARESETN = 1'b0;
    #1;
    check_val("wrst_level", wfifo_level, 3'd0);
    check_val("wrst_wvalid_mc", wvalid_mc, 1'b0);
    check_val("wrst_wready", WREADY_S, 1'b0);
    WVALID_S = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check_val("wrst_wready_back", WREADY_S, 1'b1);
    check_val("wrst_still_empty", wvalid_mc, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
